regfile_fwd_sb: RTL and testbench
=================================

# regfile_fwd_sb

Parametrised integer register file for the pipelined core: NRD combinational read ports, one writeback port, one dedicated link-register port, and a priority bypass network fed by NFWD pipeline stages. Adds a per-register pending scoreboard for multi-cycle producers and per-port stall outputs for load-use and unresolved hazards. Sits in the decode stage. Replaces the fixed 2-read / 3-stage forwarding register file.

## Interface

Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W
- NRD, 2, number of read ports
- NFWD, 3, number of forwarding stages; index 0 is youngest (EX)
- LINK_REG, 31, register written by the link port

Ports:
- Clocking and reset
  - clk  in  1  clock, rising edge
  - rst  in  1  asynchronous, active-low reset
- Read ports
  - rd_addr  in  NRD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
  - rd_data  out  NRD*DATA_W  read data
  - rd_stall  out  NRD  port i operand not yet available
- Forwarding stages
  - fwd_valid  in  NFWD  stage k will write fwd_addr[k]
  - fwd_rdy  in  NFWD  stage k data is final; 0 for a load still in flight
  - fwd_addr  in  NFWD*ADDR_W  stage k destination
  - fwd_data  in  NFWD*DATA_W  stage k result
- Writeback, link and scoreboard
  - wb_we / wb_addr / wb_data  in  1 / ADDR_W / DATA_W  architectural writeback
  - link_we / link_data  in  1 / DATA_W  writes LINK_REG
  - iss_valid / iss_addr  in  1 / ADDR_W  a multi-cycle producer issued to iss_addr; sets pending
  - flush  in  1  clears all pending bits
  - any_pending  out  1  OR of all pending bits (registered)

## Operation

Register 0:
- Reads as 0.
- Never stalls.
- Ignored as a forward, writeback, issue or pending target.

Read resolution for port i with a = rd_addr[i] ≠ 0, first match wins:
1. Lowest k with fwd_valid[k] and fwd_addr[k]==a gives fwd_data[k]. rd_stall[i] = !fwd_rdy[k]. The data is don't-care when stalled.
2. If wb_we and wb_addr==a, the result is wb_data, with no stall.
3. If a==LINK_REG and link_we, the result is link_data, with no stall.
4. Otherwise the result is regs[a]. rd_stall[i] = pending[a].

Array writes at posedge clk:
- wb_we && wb_addr≠0 writes regs[wb_addr] = wb_data.
- link_we writes regs[LINK_REG] = link_data, unless wb_we && wb_addr==LINK_REG. Writeback wins.

Scoreboard, one pending bit per register, updated at posedge:
- A clear is caused by wb_we to the address.
- A set is caused by iss_valid to iss_addr.
- Set and clear to the same address in the same cycle: set wins, because it is a new producer.
- flush clears every bit. flush has priority over a same-cycle set.

## Timing

- Reset (rst low) is asynchronous:
  - All regs = 0, all pending = 0, any_pending = 0.
  - With all fwd_valid/wb_we/link_we low, every rd_data = 0 and every rd_stall = 0.
  - Reset asserted mid-operation discards all state immediately. Writes in that cycle are lost.
- Reads and rd_stall are combinational: zero-cycle latency from addresses and bypass inputs.
- Write-to-read through the array: value visible from regs in the cycle after the edge. Same-cycle visibility comes only through bypass step 2/3.
- Pending bit visible on rd_stall in the cycle after iss_valid. It drops in the same cycle as the matching wb_we via bypass step 2. It is cleared in the array path from the next cycle.
- any_pending reflects pending state after each edge.

## Structure

- Package regfile_pkg holds the default DATA_W, ADDR_W, LINK_REG and a localparam for NREGS.
- Sub-module regfile_bypass_mux: one read port's priority resolution (steps 1–4) and stall logic. It is instantiated NRD times with a generate loop.
- Storage array, link write and scoreboard live in the top.

## Test plan

- Reset, then read r5 and r0 on both ports -> rd_data=0, rd_stall=0. Write r0=0xFFFF via wb, then read r0 -> 0.
- fwd_valid[0..2] all target r7 with data 0xA/0xB/0xC, wb r7=0xD -> rd_data=0xA. Drop stage 0 -> 0xB. Drop all forward stages -> 0xD.
- Stage 0 load to r3 with fwd_rdy[0]=0 -> rd_stall=1 on any port reading r3. Next cycle, fwd_rdy[0]=1 with data 0x55 -> 0x55, stall 0.
- iss_valid r9 -> next cycle rd_stall=1 for r9 and any_pending=1. wb_we r9=0x77 -> same cycle rd_data=0x77, stall 0. Next cycle pending clear.
- In one cycle, iss_valid r4 together with wb_we r4 -> r4 stays pending. Then flush together with iss_valid r6 -> all pending 0, any_pending=0.
- link_we 0x400 together with wb_we r31=0x100 -> r31=0x100. link_we alone -> r31=0x400, readable same cycle via bypass.

Source files
------------

// File: rtl/regfile_pkg.sv
// Default geometry shared by the register file top, its bypass mux and the bench.
package regfile_pkg;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_LINK_REG = 31;
  localparam int DEF_NREGS    = 2 ** DEF_ADDR_W;
endpackage

// File: rtl/regfile_bypass_mux.sv
// One read port: resolves the operand through the forwarding stages, writeback,
// link write and finally the array, and flags operands that are not yet final.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NFWD     = 3,
  parameter int LINK_REG = DEF_LINK_REG
) (
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic [NFWD-1:0]        i_fwd_valid,
  input  logic [NFWD-1:0]        i_fwd_rdy,
  input  logic [NFWD*ADDR_W-1:0] i_fwd_addr,
  input  logic [NFWD*DATA_W-1:0] i_fwd_data,
  input  logic                   i_wb_we,
  input  logic [ADDR_W-1:0]      i_wb_addr,
  input  logic [DATA_W-1:0]      i_wb_data,
  input  logic                   i_link_we,
  input  logic [DATA_W-1:0]      i_link_data,
  input  logic [DATA_W-1:0]      i_arr_data,
  input  logic                   i_arr_pending,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_stall
);
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] w_data;
  logic              w_stall;

  // Sources are applied lowest priority first so each later match overrides;
  // the stage loop runs oldest to youngest so stage 0 has the final say.
  always_comb begin
    w_data  = i_arr_data;
    w_stall = i_arr_pending;
    if (i_wb_we && i_wb_addr == i_addr) begin
      w_data  = i_wb_data;
      w_stall = 1'b0;
    end else if (i_link_we && i_addr == LINK_ADDR) begin
      w_data  = i_link_data;
      w_stall = 1'b0;
    end
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (i_fwd_valid[k] && i_fwd_addr[k*ADDR_W +: ADDR_W] == i_addr) begin
        w_data  = i_fwd_data[k*DATA_W +: DATA_W];
        w_stall = !i_fwd_rdy[k];
      end
    end
    if (i_addr == '0) begin
      w_data  = '0;
      w_stall = 1'b0;
    end
  end

  assign o_data  = w_data;
  assign o_stall = w_stall;
endmodule

// File: rtl/regfile_fwd_sb.sv
// Decode-stage integer register file with per-port priority bypass, a link
// register write port and a pending scoreboard for multi-cycle producers.
module regfile_fwd_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NRD      = 2,
  parameter int NFWD     = 3,
  parameter int LINK_REG = DEF_LINK_REG
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD*ADDR_W-1:0]  rd_addr,
  output logic [NRD*DATA_W-1:0]  rd_data,
  output logic [NRD-1:0]         rd_stall,
  // fwd_valid says stage k will write fwd_addr[k]; fwd_rdy says its data is
  // final. A valid-but-not-ready match stalls the reader; it never back-pressures.
  input  logic [NFWD-1:0]        fwd_valid,
  input  logic [NFWD-1:0]        fwd_rdy,
  input  logic [NFWD*ADDR_W-1:0] fwd_addr,
  input  logic [NFWD*DATA_W-1:0] fwd_data,
  input  logic                   wb_we,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   link_we,
  input  logic [DATA_W-1:0]      link_data,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_addr,
  input  logic                   flush,
  output logic                   any_pending
);
  localparam int                NREGS     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_pending;
  logic [NREGS-1:0]  w_pend_next;
  logic              r_any_pending;

  // Link goes first so a same-cycle writeback to the link register wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < NREGS; j++) r_regs[j] <= '0;
    end else begin
      if (link_we) r_regs[LINK_ADDR] <= link_data;
      if (wb_we && wb_addr != '0) r_regs[wb_addr] <= wb_data;
    end
  end

  // A new producer outranks a completing one; flush outranks everything.
  always_comb begin
    w_pend_next = r_pending;
    if (wb_we)     w_pend_next[wb_addr]  = 1'b0;
    if (iss_valid) w_pend_next[iss_addr] = 1'b1;
    if (flush)     w_pend_next           = '0;
    w_pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending     <= '0;
      r_any_pending <= 1'b0;
    end else begin
      r_pending     <= w_pend_next;
      r_any_pending <= |w_pend_next;
    end
  end

  assign any_pending = r_any_pending;

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_stall;

    assign w_addr = rd_addr[g*ADDR_W +: ADDR_W];

    regfile_bypass_mux #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NFWD     (NFWD),
      .LINK_REG (LINK_REG)
    ) u_mux (
      .i_addr        (w_addr),
      .i_fwd_valid   (fwd_valid),
      .i_fwd_rdy     (fwd_rdy),
      .i_fwd_addr    (fwd_addr),
      .i_fwd_data    (fwd_data),
      .i_wb_we       (wb_we),
      .i_wb_addr     (wb_addr),
      .i_wb_data     (wb_data),
      .i_link_we     (link_we),
      .i_link_data   (link_data),
      .i_arr_data    (r_regs[w_addr]),
      .i_arr_pending (r_pending[w_addr]),
      .o_data        (w_data),
      .o_stall       (w_stall)
    );

    assign rd_data[g*DATA_W +: DATA_W] = w_data;
    assign rd_stall[g]                 = w_stall;
  end
endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Directed walk through the register file behaviours followed by randomized
// traffic checked against an array/scoreboard reference model.
module tb_regfile_fwd_sb;
  import regfile_pkg::*;

  localparam int DW = 32, AW = 5, NRD = 2, NFWD = 3, LR = 31, NREGS = 32;

  logic                 clk, rst;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*DW-1:0]    rd_data;
  logic [NRD-1:0]       rd_stall;
  logic [NFWD-1:0]      fwd_valid, fwd_rdy;
  logic [NFWD*AW-1:0]   fwd_addr;
  logic [NFWD*DW-1:0]   fwd_data;
  logic                 wb_we, link_we, iss_valid, flush, any_pending;
  logic [AW-1:0]        wb_addr, iss_addr;
  logic [DW-1:0]        wb_data, link_data;

  regfile_fwd_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .NFWD(NFWD), .LINK_REG(LR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_stall(rd_stall),
    .fwd_valid(fwd_valid), .fwd_rdy(fwd_rdy), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .link_we(link_we),
    .link_data(link_data), .iss_valid(iss_valid), .iss_addr(iss_addr), .flush(flush),
    .any_pending(any_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] m_regs [NREGS];
  logic          m_pend [NREGS];
  logic          m_any;

  task automatic cmp(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_port(input string tag, input int i, input logic [DW-1:0] d, input logic s);
    cmp({tag, "_stall"}, {31'd0, rd_stall[i]}, {31'd0, s});
    if (!s) cmp({tag, "_data"}, rd_data[i*DW +: DW], d);
  endtask

  task automatic model_clear();
    for (int j = 0; j < NREGS; j++) begin
      m_regs[j] = '0;
      m_pend[j] = 1'b0;
    end
    m_any = 1'b0;
  endtask

  task automatic idle();
    fwd_valid = '0; fwd_rdy = '0; fwd_addr = '0; fwd_data = '0;
    wb_we = 0; wb_addr = '0; wb_data = '0; link_we = 0; link_data = '0;
    iss_valid = 0; iss_addr = '0; flush = 0;
  endtask

  task automatic set_rd(input int i, input int a);
    rd_addr[i*AW +: AW] = AW'(a);
  endtask

  task automatic set_fwd(input int k, input logic v, input logic r, input int a, input logic [DW-1:0] d);
    fwd_valid[k] = v;
    fwd_rdy[k]   = r;
    fwd_addr[k*AW +: AW] = AW'(a);
    fwd_data[k*DW +: DW] = d;
  endtask

  // Operand a as the decode stage should see it given the present bypass inputs.
  task automatic model_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic s);
    bit hit = 0;
    d = m_regs[a];
    s = m_pend[a];
    for (int k = 0; k < NFWD && !hit; k++) begin
      if (fwd_valid[k] && fwd_addr[k*AW +: AW] == a) begin
        hit = 1;
        d = fwd_data[k*DW +: DW];
        s = !fwd_rdy[k];
      end
    end
    if (!hit && wb_we && wb_addr == a) begin
      d = wb_data; s = 0;
    end else if (!hit && link_we && a == AW'(LR)) begin
      d = link_data; s = 0;
    end
    if (a == 0) begin
      d = '0; s = 0;
    end
  endtask

  task automatic check_model(input string tag);
    logic [DW-1:0] d;
    logic s;
    for (int i = 0; i < NRD; i++) begin
      model_read(rd_addr[i*AW +: AW], d, s);
      expect_port($sformatf("%s_p%0d", tag, i), i, d, s);
    end
    cmp({tag, "_any_pending"}, {31'd0, any_pending}, {31'd0, m_any});
  endtask

  // Advance one clock and apply the architectural effect of the current inputs.
  task automatic tick();
    logic [DW-1:0] nr [NREGS];
    logic          np [NREGS];
    for (int j = 0; j < NREGS; j++) begin
      nr[j] = m_regs[j];
      np[j] = m_pend[j];
    end
    if (link_we) nr[LR] = link_data;
    if (wb_we && wb_addr != 0) nr[wb_addr] = wb_data;
    if (wb_we) np[wb_addr] = 0;
    if (iss_valid) np[iss_addr] = 1;
    if (flush) for (int j = 0; j < NREGS; j++) np[j] = 0;
    np[0] = 0;
    @(posedge clk);
    #1;
    m_any = 0;
    for (int j = 0; j < NREGS; j++) begin
      m_regs[j] = nr[j];
      m_pend[j] = np[j];
      m_any |= np[j];
    end
  endtask

  function automatic int pick_addr();
    int r = $urandom_range(0, 9);
    return (r >= 8) ? LR : r;
  endfunction

  initial begin
    rst = 0; rd_addr = '0;
    idle();
    model_clear();
    set_rd(0, 5); set_rd(1, 0);
    #2;
    expect_port("rst_r5", 0, 32'h0, 0);
    expect_port("rst_r0", 1, 32'h0, 0);
    cmp("rst_any_pending", {31'd0, any_pending}, 32'd0);
    @(negedge clk); rst = 1;

    // r0 ignores writes, both same cycle and afterwards
    wb_we = 1; wb_addr = 0; wb_data = 32'hFFFF; set_rd(0, 0); set_rd(1, 0); #1;
    expect_port("r0_wb_same", 0, 32'h0, 0);
    tick(); idle(); #1;
    expect_port("r0_after_wb", 1, 32'h0, 0);

    // forwarding priority on r7
    set_rd(0, 7); set_rd(1, 7);
    set_fwd(0, 1, 1, 7, 32'hA); set_fwd(1, 1, 1, 7, 32'hB); set_fwd(2, 1, 1, 7, 32'hC);
    wb_we = 1; wb_addr = 7; wb_data = 32'hD; #1;
    expect_port("fwd_stage0", 0, 32'hA, 0);
    fwd_valid[0] = 0; #1;
    expect_port("fwd_stage1", 1, 32'hB, 0);
    fwd_valid = '0; #1;
    expect_port("fwd_wb", 0, 32'hD, 0);
    tick(); idle(); #1;
    expect_port("r7_array", 1, 32'hD, 0);

    // load-use on r3
    set_rd(0, 3); set_rd(1, 3);
    set_fwd(0, 1, 0, 3, 32'h0); #1;
    expect_port("load_p0", 0, 32'h0, 1);
    expect_port("load_p1", 1, 32'h0, 1);
    tick();
    set_fwd(0, 1, 1, 3, 32'h55); #1;
    expect_port("load_done", 0, 32'h55, 0);
    tick(); idle();

    // scoreboard on r9
    iss_valid = 1; iss_addr = 9; tick(); idle();
    set_rd(0, 9); set_rd(1, 9); #1;
    expect_port("iss_r9", 0, 32'h0, 1);
    cmp("iss_any_pending", {31'd0, any_pending}, 32'd1);
    wb_we = 1; wb_addr = 9; wb_data = 32'h77; #1;
    expect_port("wb_r9_bypass", 1, 32'h77, 0);
    tick(); idle(); #1;
    expect_port("r9_cleared", 0, 32'h77, 0);
    cmp("r9_any_pending", {31'd0, any_pending}, 32'd0);

    // set beats clear, flush beats set
    iss_valid = 1; iss_addr = 4; wb_we = 1; wb_addr = 4; wb_data = 32'h44;
    tick(); idle(); set_rd(0, 4); set_rd(1, 6); #1;
    expect_port("r4_set_wins", 0, 32'h0, 1);
    flush = 1; iss_valid = 1; iss_addr = 6;
    tick(); idle(); #1;
    expect_port("r4_flushed", 0, 32'h44, 0);
    expect_port("r6_flushed", 1, 32'h0, 0);
    cmp("flush_any_pending", {31'd0, any_pending}, 32'd0);

    // link port vs writeback on r31
    link_we = 1; link_data = 32'h400; wb_we = 1; wb_addr = 5'd31; wb_data = 32'h100;
    tick(); idle(); set_rd(0, 31); set_rd(1, 31); #1;
    expect_port("r31_wb_wins", 0, 32'h100, 0);
    link_we = 1; link_data = 32'h400; #1;
    expect_port("link_bypass", 1, 32'h400, 0);
    tick(); idle(); #1;
    expect_port("link_array", 0, 32'h400, 0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NRD; i++) set_rd(i, pick_addr());
      for (int k = 0; k < NFWD; k++)
        set_fwd(k, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), pick_addr(), $urandom);
      wb_we = $urandom_range(0, 1); wb_addr = AW'(pick_addr()); wb_data = $urandom;
      link_we = ($urandom_range(0, 3) == 0); link_data = $urandom;
      iss_valid = ($urandom_range(0, 2) == 0); iss_addr = AW'(pick_addr());
      flush = ($urandom_range(0, 15) == 0);
      #1;
      check_model("rand");
      tick();
    end

    // asynchronous reset mid-operation
    idle();
    wb_we = 1; wb_addr = 5; wb_data = 32'h1234; iss_valid = 1; iss_addr = 6;
    tick(); idle();
    set_rd(0, 5); set_rd(1, 6);
    #2 rst = 0;
    #1;
    expect_port("arst_r5", 0, 32'h0, 0);
    expect_port("arst_r6", 1, 32'h0, 0);
    cmp("arst_any_pending", {31'd0, any_pending}, 32'd0);
    model_clear();
    wb_we = 1; wb_addr = 7; wb_data = 32'h99;
    @(posedge clk); #1;
    idle();
    @(negedge clk); rst = 1;
    set_rd(0, 7); #1;
    check_model("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
